// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter merging two writeback ports (A: ALU, B: load/multi-cycle)
// into one register-file write port, plus a sequenced zero-fill of r1..r31.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_regno,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_regno,
    input  logic [31:0] b_data,
    input  logic        clr_start,
    output logic        clr_busy,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        rf_src_b
);
    // state | meaning
    // IDLE  | arbitrating A/B writebacks, accepting clr_start
    // CLEAR | writing zero to register cnt each cycle, cnt = 1..31

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ptr_q, ptr_d;          // 1: B wins the next tie
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        rf_src_b_q, rf_src_b_d;

    logic        arb_open;
    logic        grant_a;
    logic        grant_b;
    logic [4:0]  sel_regno;
    logic [31:0] sel_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = 5'd1;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // clr_start outranks both requesters, so a clear never loses a cycle to a write.
    always_comb begin
        arb_open = !rst && (state_q == IDLE) && !clr_start;
        grant_a  = arb_open && a_valid && (!b_valid || !ptr_q);
        grant_b  = arb_open && b_valid && (!a_valid || ptr_q);
        a_ready  = grant_a;
        b_ready  = grant_b;
        clr_busy = (state_q == CLEAR);
    end

    always_comb begin
        sel_regno  = grant_b ? b_regno : a_regno;
        sel_data   = grant_b ? b_data  : a_data;
        ptr_d      = ptr_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        rf_src_b_d = rf_src_b_q;
        if (state_q == CLEAR) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = cnt_q;
            rf_wdata_d = 32'd0;
            rf_src_b_d = 1'b0;
        end else if (grant_a || grant_b) begin
            // r0 writes are swallowed but still consume the grant and move the pointer
            ptr_d      = grant_a;
            rf_waddr_d = sel_regno;
            rf_wdata_d = sel_data;
            if (sel_regno != 5'd0) begin
                rf_we_d    = 1'b1;
                rf_src_b_d = grant_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
            rf_src_b_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_src_b_q <= rf_src_b_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign rf_src_b = rf_src_b_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized
// run against a behavioural model of grants, clear sequencing and register contents.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic        b_valid = 1'b0;
    logic        clr_start = 1'b0;
    logic [4:0]  a_regno = 5'd0;
    logic [4:0]  b_regno = 5'd0;
    logic [31:0] a_data = 32'd0;
    logic [31:0] b_data = 32'd0;
    logic        a_ready, b_ready, clr_busy, rf_we, rf_src_b;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_regno   (a_regno),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_regno   (b_regno),
        .b_data    (b_data),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_src_b  (rf_src_b)
    );

    // Reference model: which requester is favoured, how many zero-fill writes remain,
    // the expected write port, and shadow register files (model vs. observed writes).
    bit          m_fav_b;
    int          m_clear_left;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_srcb;
    logic [31:0] m_rf [32];
    logic [31:0] d_rf [32];

    function automatic void m_ready(output bit ar, output bit br);
        ar = 1'b0;
        br = 1'b0;
        if (rst || m_clear_left > 0 || clr_start) return;
        if (a_valid && b_valid) begin
            ar = !m_fav_b;
            br = m_fav_b;
        end else begin
            ar = a_valid;
            br = b_valid;
        end
    endfunction

    function automatic void m_edge();
        bit          ar, br;
        logic [4:0]  regno;
        logic [31:0] data;
        m_ready(ar, br);
        m_we = 1'b0;
        if (rst) begin
            m_fav_b      = 1'b0;
            m_clear_left = 0;
            m_waddr      = 5'd0;
            m_wdata      = 32'd0;
            m_srcb       = 1'b0;
        end else if (m_clear_left > 0) begin
            m_we         = 1'b1;
            m_waddr      = 5'(32 - m_clear_left);
            m_wdata      = 32'd0;
            m_srcb       = 1'b0;
            m_clear_left = m_clear_left - 1;
        end else if (clr_start) begin
            m_clear_left = 31;
        end else if (ar || br) begin
            regno   = ar ? a_regno : b_regno;
            data    = ar ? a_data  : b_data;
            m_waddr = regno;
            m_wdata = data;
            if (regno != 5'd0) begin
                m_we   = 1'b1;
                m_srcb = br;
            end
            m_fav_b = ar;
        end
        if (m_we) m_rf[m_waddr] = m_wdata;
    endfunction

    // Advance one clock: update the model with the inputs seen at this edge,
    // then return 1 time unit after the edge with the DUT's write recorded.
    task automatic tick();
        m_edge();
        @(posedge clk);
        #1;
        if (rf_we === 1'b1) d_rf[rf_waddr] = rf_wdata;
    endtask

    task automatic idle_inputs();
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_regno = 5'd3; b_regno = 5'd4;
        #1;
        vectors++;
        if ({a_ready, b_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready: got %b, expected 00", {a_ready, b_ready});
        end
        tick();
        tick();
        vectors++;
        if ({rf_we, rf_src_b, clr_busy, rf_waddr, rf_wdata} !== 40'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got we=%b src_b=%b busy=%b addr=%0d data=%h, expected all 0",
                     rf_we, rf_src_b, clr_busy, rf_waddr, rf_wdata);
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single();
        a_valid = 1'b1; a_regno = 5'd5; a_data = 32'h1234_5678;
        #1;
        vectors++;
        if ({a_ready, b_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_ready: got %b, expected 10", {a_ready, b_ready});
        end
        tick();
        a_valid = 1'b0;
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata, rf_src_b} !== {1'b1, 5'd5, 32'h1234_5678, 1'b0}) begin
            miscompares++;
            $display("FAIL single_write: got we=%b addr=%0d data=%h src_b=%b, expected 1/5/12345678/0",
                     rf_we, rf_waddr, rf_wdata, rf_src_b);
        end
        tick();
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd5, 32'h1234_5678}) begin
            miscompares++;
            $display("FAIL single_hold: got we=%b addr=%0d data=%h, expected 0/5/12345678",
                     rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_contention();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_valid = 1'b1; a_regno = 5'd3; a_data = 32'hAAAA_0003;
        b_valid = 1'b1; b_regno = 5'd4; b_data = 32'hBBBB_0004;
        for (int i = 0; i < 4; i++) begin
            bit odd;
            odd = (i % 2) == 1;
            #1;
            vectors++;
            if ({a_ready, b_ready} !== {!odd, odd}) begin
                miscompares++;
                $display("FAIL contention_ready[%0d]: got %b, expected %b", i, {a_ready, b_ready}, {!odd, odd});
            end
            tick();
            vectors++;
            if ({rf_we, rf_src_b, rf_waddr, rf_wdata} !==
                {1'b1, odd, (odd ? 5'd4 : 5'd3), (odd ? 32'hBBBB_0004 : 32'hAAAA_0003)}) begin
                miscompares++;
                $display("FAIL contention_write[%0d]: got we=%b src_b=%b addr=%0d data=%h, expected src_b=%b",
                         i, rf_we, rf_src_b, rf_waddr, rf_wdata, odd);
            end
        end
        idle_inputs();
    endtask

    task automatic test_regzero();
        // A-only grant first so the pointer favours B before the r0 write
        a_valid = 1'b1; a_regno = 5'd7; a_data = $urandom;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b1; b_regno = 5'd0; b_data = 32'hFFFF_FFFF;
        #1;
        vectors++;
        if ({a_ready, b_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL regzero_ready: got %b, expected 01", {a_ready, b_ready});
        end
        tick();
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata, rf_src_b} !== {1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0}) begin
            miscompares++;
            $display("FAIL regzero_write: got we=%b addr=%0d data=%h src_b=%b, expected 0/0/ffffffff/0",
                     rf_we, rf_waddr, rf_wdata, rf_src_b);
        end
        a_valid = 1'b1; a_regno = 5'd7; b_regno = 5'd8;
        #1;
        vectors++;
        if ({a_ready, b_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL regzero_pointer: got %b, expected 10", {a_ready, b_ready});
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_clear();
        logic [31:0] pend;
        pend = $urandom;
        a_valid = 1'b1; a_regno = 5'd9; a_data = pend; clr_start = 1'b1;
        #1;
        vectors++;
        if ({a_ready, b_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL clear_start_ready: got %b, expected 00", {a_ready, b_ready});
        end
        tick();
        for (int k = 1; k <= 31; k++) begin
            clr_start = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if ({a_ready, clr_busy} !== 2'b01) begin
                miscompares++;
                $display("FAIL clear_busy[%0d]: got ready=%b busy=%b, expected 0/1", k, a_ready, clr_busy);
            end
            tick();
            vectors++;
            if ({rf_we, rf_waddr, rf_wdata, rf_src_b} !== {1'b1, 5'(k), 32'd0, 1'b0}) begin
                miscompares++;
                $display("FAIL clear_write[%0d]: got we=%b addr=%0d data=%h src_b=%b, expected 1/%0d/0/0",
                         k, rf_we, rf_waddr, rf_wdata, rf_src_b, k);
            end
        end
        clr_start = 1'b0;
        #1;
        vectors++;
        if ({a_ready, b_ready, clr_busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL clear_release: got ready=%b%b busy=%b, expected 10/0", a_ready, b_ready, clr_busy);
        end
        tick();
        a_valid = 1'b0;
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata, rf_src_b} !== {1'b1, 5'd9, pend, 1'b0}) begin
            miscompares++;
            $display("FAIL clear_pending_write: got we=%b addr=%0d data=%h src_b=%b, expected 1/9/%h/0",
                     rf_we, rf_waddr, rf_wdata, rf_src_b, pend);
        end
    endtask

    task automatic test_reset_mid_clear();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (9) tick();
        rst = 1'b1; a_valid = 1'b1;
        #1;
        vectors++;
        if ({a_ready, b_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL midclear_rst_ready: got %b, expected 00", {a_ready, b_ready});
        end
        tick();
        rst = 1'b0;
        vectors++;
        if ({rf_we, clr_busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL midclear_abort: got we=%b busy=%b, expected 0/0", rf_we, clr_busy);
        end
        b_valid = 1'b1; a_regno = 5'd1; b_regno = 5'd2;
        #1;
        vectors++;
        if ({a_ready, b_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL midclear_pointer: got %b, expected 10", {a_ready, b_ready});
        end
        tick();
        idle_inputs();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        tick();
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 32'd0}) begin
            miscompares++;
            $display("FAIL midclear_restart: got we=%b addr=%0d data=%h, expected 1/1/0", rf_we, rf_waddr, rf_wdata);
        end
        repeat (30) tick();
        vectors++;
        if ({clr_busy, rf_we, rf_waddr} !== {1'b0, 1'b1, 5'd31}) begin
            miscompares++;
            $display("FAIL midclear_finish: got busy=%b we=%b addr=%0d, expected 0/1/31", clr_busy, rf_we, rf_waddr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit ar, br;
            rst       = ($urandom_range(0, 99) < 2);
            clr_start = ($urandom_range(0, 59) == 0);
            a_valid   = 1'($urandom_range(0, 1));
            b_valid   = 1'($urandom_range(0, 1));
            a_regno   = 5'($urandom_range(0, 6));
            b_regno   = 5'($urandom_range(0, 6));
            a_data    = $urandom;
            b_data    = $urandom;
            #1;
            m_ready(ar, br);
            vectors++;
            if ({a_ready, b_ready, clr_busy} !== {ar, br, (m_clear_left > 0)}) begin
                miscompares++;
                $display("FAIL random_ready[%0d]: got a=%b b=%b busy=%b, expected a=%b b=%b busy=%b",
                         i, a_ready, b_ready, clr_busy, ar, br, (m_clear_left > 0));
            end
            tick();
            vectors++;
            if ({rf_we, rf_waddr, rf_wdata, rf_src_b} !== {m_we, m_waddr, m_wdata, m_srcb}) begin
                miscompares++;
                $display("FAIL random_write[%0d]: got we=%b addr=%0d data=%h src_b=%b, expected we=%b addr=%0d data=%h src_b=%b",
                         i, rf_we, rf_waddr, rf_wdata, rf_src_b, m_we, m_waddr, m_wdata, m_srcb);
            end
        end
        rst = 1'b0;
        idle_inputs();
        repeat (32) tick();
        for (int r = 1; r < 32; r++) begin
            vectors++;
            if (d_rf[r] !== m_rf[r]) begin
                miscompares++;
                $display("FAIL random_regfile[r%0d]: got %h, expected %h", r, d_rf[r], m_rf[r]);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_rf[r] = 32'd0;
            d_rf[r] = 32'd0;
        end
        test_reset();
        test_single();
        test_contention();
        test_regzero();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
